// File: rtl/ram_read_sequencer_pkg.sv
// rtl/ram_read_sequencer_pkg.sv - shared widths and FSM encoding for the RAM read sequencer
package ram_read_sequencer_pkg;
   localparam int ADDR_W = 13;
   localparam int DATA_W = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } seq_state_e;
endpackage

// File: rtl/ram_read_sequencer_if.sv
// rtl/ram_read_sequencer_if.sv - RAM read port and output word stream of the sequencer
interface ram_read_sequencer_if;
   import ram_read_sequencer_pkg::*;

   logic [ADDR_W-1:0] ram_addr;
   logic              ram_re;
   logic [DATA_W-1:0] ram_q;
   logic [DATA_W-1:0] dout;
   logic              dout_valid;
   logic              dout_ready;

   modport master (
      output ram_addr, ram_re, dout, dout_valid,
      input  ram_q, dout_ready
   );

   modport slave (
      input  ram_addr, ram_re, dout, dout_valid,
      output ram_q, dout_ready
   );
endinterface

// File: rtl/ram_rd_fifo.sv
// rtl/ram_rd_fifo.sv - show-ahead FIFO absorbing RAM latency and consumer backpressure
module ram_rd_fifo #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic [DATA_W-1:0]            din,
   input  logic                         pop,
   output logic [DATA_W-1:0]            dout,
   output logic                         empty,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic              do_push;
   logic              do_pop;

   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // a pop in the same cycle frees the slot, so a full FIFO still takes the push
   assign do_push = push && ((count != FULL_CNT) || do_pop);
   assign dout    = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/ram_read_sequencer.sv
// rtl/ram_read_sequencer.sv - streams RAM words [firstaddr, lastaddr) to a consumer, one read per cycle
module ram_read_sequencer
   import ram_read_sequencer_pkg::*;
#(
   parameter int RAM_LAT = 1,
   parameter int DEPTH   = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic                 re_RAM,
   input  logic [ADDR_W-1:0]    firstaddr,
   input  logic [ADDR_W-1:0]    lastaddr,
   ram_read_sequencer_if.master bus,
   output logic                 busy,
   output logic                 done
);
   localparam int CNT_W = $clog2(DEPTH + 1);

   seq_state_e         state, state_n;
   logic [ADDR_W-1:0]  addr_q, addr_n;
   logic [ADDR_W-1:0]  end_q, end_n;
   logic               issue;
   logic [ADDR_W-1:0]  issue_addr;
   logic [RAM_LAT-1:0] vld;
   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_empty;
   logic               pop;
   logic               credit_ok;
   logic               drained;

   assign pop            = bus.dout_valid && bus.dout_ready;
   assign bus.dout_valid = !fifo_empty;
   assign busy           = (state != IDLE);
   assign done           = (state == DONE);

   // every word between the RAM and the consumer holds a FIFO slot in reserve
   assign credit_ok = (int'(fifo_count) + $countones({bus.ram_re, vld})) < DEPTH;
   assign drained   = !bus.ram_re && (vld == '0) &&
                      (fifo_empty || ((fifo_count == CNT_W'(1)) && pop));

   always_comb begin
      state_n    = state;
      addr_n     = addr_q;
      end_n      = end_q;
      issue      = 1'b0;
      issue_addr = addr_q;
      case (state)
         IDLE: begin
            if (start && re_RAM) begin
               addr_n = firstaddr;
               end_n  = lastaddr;
               if (firstaddr >= lastaddr) begin
                  state_n = DONE;
               end else begin
                  // first read goes out with the accept so ram_re rises with busy
                  issue      = 1'b1;
                  issue_addr = firstaddr;
                  if (firstaddr + ADDR_W'(1) == lastaddr) begin
                     state_n = DRAIN;
                  end else begin
                     addr_n  = firstaddr + ADDR_W'(1);
                     state_n = READ;
                  end
               end
            end
         end
         READ: begin
            if (credit_ok) begin
               issue = 1'b1;
               if (addr_q + ADDR_W'(1) == end_q) state_n = DRAIN;
               else                              addr_n  = addr_q + ADDR_W'(1);
            end
         end
         DRAIN: begin
            if (drained) state_n = DONE;
         end
         DONE: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         addr_q       <= '0;
         end_q        <= '0;
         bus.ram_re   <= 1'b0;
         bus.ram_addr <= '0;
         vld          <= '0;
      end else begin
         state      <= state_n;
         addr_q     <= addr_n;
         end_q      <= end_n;
         bus.ram_re <= issue;
         if (issue) bus.ram_addr <= issue_addr;
         vld[0] <= bus.ram_re;
         for (int i = 1; i < RAM_LAT; i++) vld[i] <= vld[i-1];
      end
   end

   ram_rd_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (vld[RAM_LAT-1]),
      .din   (bus.ram_q),
      .pop   (pop),
      .dout  (bus.dout),
      .empty (fifo_empty),
      .count (fifo_count)
   );
endmodule
